// File: rtl/vga_framebuf.sv
// vga_framebuf: double-buffered pixel store between a frame writer and a
// VGA scan-out reader.
//
// The writer fills the back bank through a valid/ready port and pulses
// wr_frame_done when it has finished a frame. The banks swap at the next
// end-of-frame: the cycle the reader samples the last visible pixel. While
// a swap is waiting, the writer is stalled. If a frame ends with no swap
// requested, frame_drop pulses and the same front bank is shown again.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   wr_valid/wr_ready          write handshake (wr_ready = ~swap_pending)
//   wr_addr, wr_data           linear back-bank address and pixel
//   wr_frame_done              writer finished the back frame (1-cycle pulse)
//   rd_h, rd_v                 display column/line being fetched
//   rd_data                    front-bank pixel, 1 cycle after rd_h/rd_v
//   front_sel                  bank being displayed (0 = bank A)
//   swap_pending               swap requested but not yet performed
//   frame_drop                 1-cycle pulse: front bank repeated
//   frame_count                completed swaps, wraps at 8 bits
module vga_framebuf #(
  parameter int DATA_W   = 8,
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int H_W      = 10,
  parameter int V_W      = 10,
  parameter int ADDR_W   = 19,
  parameter int BLANK    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  input  logic [H_W-1:0]    rd_h,
  input  logic [V_W-1:0]    rd_v,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_sel,
  output logic              swap_pending,
  output logic              frame_drop,
  output logic [7:0]        frame_count
);

  localparam int                DEPTH   = H_PIXELS * V_PIXELS;
  localparam logic [DATA_W-1:0] BLANK_V = DATA_W'(BLANK);

  // Pixel storage: one write port and one read port per bank, no reset,
  // so each maps onto block RAM.
  logic [DATA_W-1:0] r_bank_a [DEPTH];
  logic [DATA_W-1:0] r_bank_b [DEPTH];
  logic [DATA_W-1:0] r_rd_a, r_rd_b;

  logic       r_front, r_pend, r_drop, r_eof_d;
  logic [7:0] r_cnt;
  logic       r_rd_vld, r_rd_sel, r_rd_blank;

  logic              w_wr_acc, w_wr_a, w_wr_b;
  logic              w_rd_oob, w_eof, w_eof_evt, w_swap;
  logic [ADDR_W-1:0] w_rd_addr;

  // ---------------------------------------------------------------- write
  assign wr_ready = ~rst & ~r_pend;
  // Out-of-range addresses complete the handshake but touch nothing.
  assign w_wr_acc = wr_valid & wr_ready & (32'(wr_addr) < DEPTH);
  // The back bank is the one not displayed.
  assign w_wr_a   = w_wr_acc &  r_front;
  assign w_wr_b   = w_wr_acc & ~r_front;

  // ----------------------------------------------------------------- read
  assign w_rd_oob  = (32'(rd_h) >= H_PIXELS) || (32'(rd_v) >= V_PIXELS);
  assign w_rd_addr = w_rd_oob ? '0
                   : ADDR_W'(32'(rd_v) * H_PIXELS + 32'(rd_h));

  always_ff @(posedge clk) begin
    if (w_wr_a) r_bank_a[wr_addr] <= wr_data;
    r_rd_a <= r_bank_a[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_wr_b) r_bank_b[wr_addr] <= wr_data;
    r_rd_b <= r_bank_b[w_rd_addr];
  end

  // Both banks are read every cycle. The bank select and blank flag are
  // captured with the address, so a swap on the same edge cannot change
  // which bank the in-flight pixel comes from. r_rd_vld forces 0 until the
  // first read after reset has been sampled.
  assign rd_data = !r_rd_vld  ? '0
                 : r_rd_blank ? BLANK_V
                 : r_rd_sel   ? r_rd_b : r_rd_a;

  // ------------------------------------------------------- frame control
  assign w_eof     = (32'(rd_h) == H_PIXELS - 1) && (32'(rd_v) == V_PIXELS - 1);
  // Count an EOF only on the cycle it is entered.
  assign w_eof_evt = w_eof & ~r_eof_d;
  // A done pulse coinciding with EOF swaps immediately.
  assign w_swap    = w_eof_evt & (r_pend | wr_frame_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front    <= 1'b0;
      r_pend     <= 1'b0;
      r_drop     <= 1'b0;
      r_eof_d    <= 1'b0;
      r_cnt      <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rd_blank <= 1'b0;
    end else begin
      r_eof_d    <= w_eof;
      r_rd_vld   <= 1'b1;
      r_rd_sel   <= r_front;
      r_rd_blank <= w_rd_oob;
      r_drop     <= w_eof_evt & ~r_pend & ~wr_frame_done;
      if (w_swap) begin
        r_front <= ~r_front;
        r_pend  <= 1'b0;
        r_cnt   <= r_cnt + 8'd1;
      end else if (wr_frame_done) begin
        r_pend  <= 1'b1;
      end
    end
  end

  assign front_sel    = r_front;
  assign swap_pending = r_pend;
  assign frame_drop   = r_drop;
  assign frame_count  = r_cnt;

endmodule

// File: tb/tb_vga_framebuf.sv
module tb_vga_framebuf;
  localparam int HP = 640, VP = 480, DEPTH = HP * VP;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_valid = 1'b0, wr_frame_done = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [9:0]  rd_h = '0, rd_v = '0;
  logic        wr_ready, front_sel, swap_pending, frame_drop;
  logic [7:0]  rd_data, frame_count;

  always #5 clk = ~clk;

  vga_framebuf #(.DATA_W(8), .H_PIXELS(HP), .V_PIXELS(VP), .H_W(10), .V_W(10),
                 .ADDR_W(19), .BLANK(0)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_frame_done(wr_frame_done),
    .rd_h(rd_h), .rd_v(rd_v), .rd_data(rd_data), .front_sel(front_sel),
    .swap_pending(swap_pending), .frame_drop(frame_drop),
    .frame_count(frame_count));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: banks as a sparse map keyed by bank*DEPTH+addr;
  // frame rules applied directly from the behaviour description.
  logic [7:0] mbank [int];
  bit         m_front, m_pend, m_drop, m_prev_eof, m_rd_known;
  logic [7:0] m_cnt = '0, m_rd = '0;

  always @(posedge clk or posedge rst) begin
    bit eof, evt;
    int key;
    if (rst) begin
      m_front = 0; m_pend = 0; m_drop = 0; m_prev_eof = 0;
      m_cnt = '0; m_rd = '0; m_rd_known = 1;
    end else begin
      eof = (int'(rd_h) == HP - 1) && (int'(rd_v) == VP - 1);
      evt = eof && !m_prev_eof;
      m_prev_eof = eof;
      if (int'(rd_h) >= HP || int'(rd_v) >= VP) begin
        m_rd = 8'h00; m_rd_known = 1;
      end else begin
        key = int'(m_front) * DEPTH + int'(rd_v) * HP + int'(rd_h);
        m_rd_known = mbank.exists(key) != 0;
        m_rd = m_rd_known ? mbank[key] : 8'h00;
      end
      if (wr_valid && !m_pend && int'(wr_addr) < DEPTH)
        mbank[int'(!m_front) * DEPTH + int'(wr_addr)] = wr_data;
      m_drop = evt && !m_pend && !wr_frame_done;
      if (evt && (m_pend || wr_frame_done)) begin
        m_front = !m_front; m_pend = 0; m_cnt = m_cnt + 8'd1;
      end else if (wr_frame_done) begin
        m_pend = 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("front_sel",    32'(front_sel),    32'(m_front));
    chk("swap_pending", 32'(swap_pending), 32'(m_pend));
    chk("wr_ready",     32'(wr_ready),     32'(!rst && !m_pend));
    chk("frame_drop",   32'(frame_drop),   32'(m_drop));
    chk("frame_count",  32'(frame_count),  32'(m_cnt));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rd(input logic [9:0] h, input logic [9:0] v);
    rd_h = h; rd_v = v;
  endtask

  task automatic do_wr(input logic [18:0] a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst wr_ready",    32'(wr_ready),    32'd0);
    chk("rst front_sel",   32'(front_sel),   32'd0);
    chk("rst rd_data",     32'(rd_data),     32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0; #1;
    chk("ready after rst", 32'(wr_ready), 32'd1);

    // Basic write, swap, read back
    do_wr(19'd0, 8'hA5);
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    chk("pending set", 32'(swap_pending), 32'd1);
    chk("stalled",     32'(wr_ready),     32'd0);
    do_wr(19'd0, 8'h77);                 // not accepted while stalled
    chk("still pending", 32'(swap_pending), 32'd1);
    set_rd(10'd639, 10'd479); tick(); set_rd(10'd0, 10'd0);
    chk("swap1 front", 32'(front_sel),   32'd1);
    chk("swap1 count", 32'(frame_count), 32'd1);
    chk("swap1 clear", 32'(swap_pending), 32'd0);
    tick();
    chk("read A5", 32'(rd_data), 32'hA5);

    // EOF with no frame done: drop pulse only
    set_rd(10'd639, 10'd479); tick(); set_rd(10'd0, 10'd0);
    chk("drop pulse",  32'(frame_drop),  32'd1);
    chk("drop front",  32'(front_sel),   32'd1);
    chk("drop count",  32'(frame_count), 32'd1);
    tick();
    chk("drop 1 cycle", 32'(frame_drop), 32'd0);

    // frame_done coinciding with EOF
    do_wr(19'd1, 8'h3C);
    set_rd(10'd639, 10'd479); wr_frame_done = 1'b1; tick();
    wr_frame_done = 1'b0; set_rd(10'd1, 10'd0);
    chk("same-cycle front", 32'(front_sel),    32'd0);
    chk("same-cycle count", 32'(frame_count),  32'd2);
    chk("same-cycle pend",  32'(swap_pending), 32'd0);
    tick();
    chk("read 3C", 32'(rd_data), 32'h3C);

    // Out-of-range reads and writes
    set_rd(10'd640, 10'd0); tick();
    chk("blank h", 32'(rd_data), 32'h00);
    set_rd(10'd0, 10'd480); tick();
    chk("blank v", 32'(rd_data), 32'h00);
    set_rd(10'd0, 10'd0);
    do_wr(19'd307200, 8'hFF);
    do_wr(19'd307199, 8'h5A);
    do_wr(19'd2, 8'h11);

    // Reset while a swap is pending
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    chk("pend before rst", 32'(swap_pending), 32'd1);
    rst = 1'b1; #1;
    chk("rst pend",  32'(swap_pending), 32'd0);
    chk("rst front", 32'(front_sel),    32'd0);
    chk("rst ready", 32'(wr_ready),     32'd0);
    chk("rst rd",    32'(rd_data),      32'd0);
    chk("rst count", 32'(frame_count),  32'd0);
    tick(); tick();
    rst = 1'b0; tick();
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    set_rd(10'd639, 10'd479); tick(); set_rd(10'd2, 10'd0);
    chk("post-rst front", 32'(front_sel),   32'd1);
    chk("post-rst count", 32'(frame_count), 32'd1);
    tick();
    chk("read 11", 32'(rd_data), 32'h11);
    set_rd(10'd0, 10'd0); tick();
    chk("read A5 again", 32'(rd_data), 32'hA5);
    set_rd(10'd639, 10'd479); tick(); set_rd(10'd0, 10'd0);
    chk("read last px", 32'(rd_data),    32'h5A);
    chk("last px drop", 32'(frame_drop), 32'd1);
    tick();

    // EOF held 3 cycles: one swap
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    set_rd(10'd639, 10'd479); repeat (3) tick(); set_rd(10'd0, 10'd0);
    chk("held front", 32'(front_sel),   32'd0);
    chk("held count", 32'(frame_count), 32'd2);
    chk("held pend",  32'(swap_pending), 32'd0);
    tick();

    // Counter wrap
    for (int i = 0; i < 253; i++) begin
      wr_frame_done = 1'b1; set_rd(10'd639, 10'd479); tick();
      wr_frame_done = 1'b0; set_rd(10'd0, 10'd0); tick();
    end
    chk("count 255", 32'(frame_count), 32'd255);
    wr_frame_done = 1'b1; set_rd(10'd639, 10'd479); tick();
    wr_frame_done = 1'b0; set_rd(10'd0, 10'd0); tick();
    chk("count wrap",  32'(frame_count), 32'd0);
    chk("wrap front",  32'(front_sel),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
